// File: rtl/bit_serializer_if.sv
// Handshake/stream bundle for bit_serializer: word push side and serial bit side.
// master = word producer / bit consumer, slave = the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, dout, dout_valid, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: DEPTH-entry word FIFO feeding an MSB-first shifter.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int IW = $clog2(FRAME);
  localparam logic [IW-1:0] LAST = IW'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             push, pop, last;
  logic [WIDTH-1:0] head;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par;
`endif

  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early
  assign bus.in_ready = !reset && (count < (AW+1)'(DEPTH));
  assign push = bus.in_valid && bus.in_ready;
  assign last = (state == SHIFT) && (idx == LAST);
  assign pop  = (count != '0) && ((state == IDLE) || last);
  assign head = mem[rd_ptr];
  assign bus.busy = (count != '0) || (state == SHIFT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= IDLE;
      shreg          <= '0;
      idx            <= '0;
      bus.dout       <= 1'b0;
      bus.dout_valid <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par            <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        // load on the edge after the previous frame's last bit: zero-gap streaming
        state          <= SHIFT;
        shreg          <= head;
        idx            <= '0;
        bus.dout       <= head[WIDTH-1];
        bus.dout_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        par            <= ^head;
`endif
      end else if (last) begin
        state          <= IDLE;
        idx            <= '0;
        bus.dout       <= 1'b0;
        bus.dout_valid <= 1'b0;
      end else if (state == SHIFT) begin
        idx   <= idx + 1'b1;
        shreg <= {shreg[WIDTH-2:0], 1'b0};
`ifdef BIT_SERIALIZER_PARITY_EN
        bus.dout <= (idx == IW'(WIDTH - 1)) ? par : shreg[WIDTH-2];
`else
        bus.dout <= shreg[WIDTH-2];
`endif
      end
    end
  end
endmodule
